palindrome_tx: RTL
==================

# palindrome_tx

Serial palindrome frame transmitter. It is the source end of the one-bit-per-cycle serial stream consumed by the palindrome detector. Each frame is accepted as a parallel half-word over a valid/ready handshake and emitted LSB-first, then mirrored back, so every frame is a bit palindrome. Used as stimulus source and loopback partner for the detector.

## Interface
- HALF_W, 4, width of the half-word payload; legal range 1..16.
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_i  input  1  payload valid.
- data_i  input  HALF_W  half-word; bit 0 is transmitted first.
- mid_i  input  1  frame centre bit; used only when PALTX_MID_BIT_EN is defined.
- ready_o  output  1  transmitter can accept a payload this cycle.
- x_o  output  1  serial bit; 0 whenever x_vld_o=0.
- x_vld_o  output  1  x_o carries a frame bit.
- sof_o  output  1  first bit of the frame.
- eof_o  output  1  last bit of the frame.

## Operation
- A payload is accepted on a rising edge where valid_i=1 and ready_o=1. data_i and mid_i are captured into internal registers at that edge. Later changes on the inputs have no effect on the frame.
- Frame length L = 2*HALF_W, or 2*HALF_W+1 when the macro is enabled.
- Bit order: d[0], d[1], …, d[HALF_W-1], [m], d[HALF_W-1], …, d[0].
- FSM states:
  - IDLE: no frame in flight; ready_o=1.
  - FWD: index counts 0 up to HALF_W-1.
  - MID: one cycle; exists only with the macro.
  - REV: index counts HALF_W-1 down to 0.
- Transitions:
  - IDLE goes to FWD on accept.
  - FWD, at index HALF_W-1, goes to MID when the macro is on, otherwise to REV. REV starts at index HALF_W-1.
  - MID goes to REV.
  - REV, at index 0 (the eof cycle), goes to FWD if a new payload is accepted in the same cycle, otherwise to IDLE.
- ready_o = (state==IDLE) | eof_o, and is forced to 0 while reset=1.
- The index counter is $clog2(HALF_W+1) bits wide. It never wraps outside 0..HALF_W-1. With HALF_W=1, the FWD and REV states each last exactly one cycle.
- sof_o and eof_o are each asserted for exactly one cycle per frame, and only together with x_vld_o=1.
- Reset:
  - reset=1 at any time, including mid-frame, aborts the frame. No eof_o is produced for the aborted frame.
  - The cycle after the reset edge: state=IDLE; x_o, x_vld_o, sof_o and eof_o are all 0.
  - ready_o returns to 1 in the first cycle with reset=0.

## Timing
- x_o, x_vld_o, sof_o and eof_o are registered outputs. ready_o is combinational from state and eof_o.
- Latency: a payload accepted at edge k drives x_vld_o=1 for cycles k+1 through k+L, with sof_o at k+1 and eof_o at k+L.
- Back-to-back: a payload accepted at the eof edge produces its sof_o in the next cycle, with no idle gap. Sustained throughput is 1 bit/cycle.
- A payload accepted from IDLE after a gap starts on the next cycle. There is no extra bubble.
- valid_i=1 while ready_o=0 is held off without loss. The source must hold valid_i and data_i stable until accepted.

## Configuration
- PALTX_MID_BIT_EN:
  - Defined: odd-length frames (L=2*HALF_W+1). mid_i is captured at accept and sent in the MID state. With HALF_W=1 this yields 3-bit palindromes {d0, m, d0}, which the palindrome detector flags.
  - Undefined: even-length frames (L=2*HALF_W). The MID state does not exist and mid_i is ignored.

## Test plan
- Reset, then idle: x_o, x_vld_o, sof_o and eof_o are 0 after the reset edge. ready_o=0 during reset and 1 after.
- HALF_W=4, macro off, data_i=4'b1011 accepted at edge 0 -> x_o = 1,1,0,1,1,0,1,1 on cycles 1..8; sof_o on cycle 1, eof_o on cycle 8.
- Back-to-back: 4'b0001 then 4'b1110, with valid_i held high -> 16 consecutive x_vld_o cycles. Output is 1,0,0,0,0,0,0,1, then 0,1,1,1,1,1,1,0. ready_o is high only on cycle 0 and on cycle 8.
- Macro on, HALF_W=1, data_i=1, mid_i=0 -> x_o = 1,0,1. When fed to the detector, it reports a palindrome on the third bit.
- Reset asserted on cycle 3 of a frame -> x_vld_o=0 on cycle 4 with no eof_o. A new payload is accepted once reset=0 and starts with sof_o.
- data_i toggled every cycle after acceptance -> the transmitted frame matches the captured value only.

Source files
------------

// File: rtl/palindrome_tx.sv
// Serial palindrome frame transmitter: a half-word is sent LSB-first and then mirrored back.
// Optional centre bit (odd-length frames) is enabled by defining PALTX_MID_BIT_EN.
module palindrome_tx #(
    parameter int unsigned HALF_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [HALF_W-1:0] data_i,
    input  logic              mid_i,
    output logic              ready_o,
    output logic              x_o,
    output logic              x_vld_o,
    output logic              sof_o,
    output logic              eof_o
);

    localparam int unsigned IDX_W = $clog2(HALF_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HALF_W - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
`ifdef PALTX_MID_BIT_EN
    localparam logic [1:0] ST_MID  = 2'd2;
`endif
    localparam logic [1:0] ST_REV  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HALF_W-1:0] data_q, data_d;
    logic              x_q, x_d;
    logic              xv_q, xv_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic              accept;
    logic              sel_bit;

`ifdef PALTX_MID_BIT_EN
    logic              mid_q, mid_d;
`else
    logic              unused_mid;
    assign unused_mid = mid_i;
`endif

    assign ready_o = ~reset & ((state_q == ST_IDLE) | eof_q);
    assign accept  = valid_i & ready_o;

    // State and index describe the bit being driven in the next cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
`ifdef PALTX_MID_BIT_EN
        mid_d   = mid_q;
`endif
        if (accept) begin
            data_d = data_i;
`ifdef PALTX_MID_BIT_EN
            mid_d  = mid_i;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_FWD;
                    idx_d   = '0;
                end
            end
            ST_FWD: begin
                if (idx_q == LAST_IDX) begin
`ifdef PALTX_MID_BIT_EN
                    state_d = ST_MID;
`else
                    state_d = ST_REV;
`endif
                    idx_d   = LAST_IDX;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
`ifdef PALTX_MID_BIT_EN
            ST_MID: begin
                state_d = ST_REV;
                idx_d   = LAST_IDX;
            end
`endif
            ST_REV: begin
                if (idx_q == '0) begin
                    if (accept) begin
                        state_d = ST_FWD;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        sel_bit = 1'b0;
        for (int unsigned i = 0; i < HALF_W; i++) begin
            if (idx_d == IDX_W'(i)) begin
                sel_bit = data_d[i];
            end
        end
    end

    always_comb begin
        xv_d  = (state_d != ST_IDLE);
        sof_d = accept;
        eof_d = (state_d == ST_REV) && (idx_d == '0);
        x_d   = 1'b0;
        if ((state_d == ST_FWD) || (state_d == ST_REV)) begin
            x_d = sel_bit;
        end
`ifdef PALTX_MID_BIT_EN
        else if (state_d == ST_MID) begin
            x_d = mid_d;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

`ifdef PALTX_MID_BIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mid_q <= 1'b0;
        end else begin
            mid_q <= mid_d;
        end
    end
`endif

    assign x_o     = x_q;
    assign x_vld_o = xv_q;
    assign sof_o   = sof_q;
    assign eof_o   = eof_q;

endmodule
